// File: rtl/kgp_fetch_pkg.sv
// Shared definitions for the instruction fetch controller: FSM state
// encoding, default PC increment and the PC alignment helper.
package kgp_fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DRAIN,
    S_HOLD,
    S_ERR
  } fetch_state_t;

  localparam int         PC_STEP_DEF = 4;
  localparam logic [1:0] ALIGN_MASK  = 2'b11;

  // A PC is fetchable only when its low address bits are clear.
  function automatic logic pc_aligned(input logic [1:0] pc_lsb);
    return (pc_lsb & ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_out_buf.sv
// Capture register for the instruction handed to decode and its address.
// Loads on load, clears synchronously on clr; otherwise holds, so the
// word stays stable for as long as decode is looking at it.
module fetch_out_buf #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              load,
  input  logic [DATA_W-1:0] instr_p0,
  input  logic [DATA_W-1:0] pc_p0,
  output logic [DATA_W-1:0] instr_p1,
  output logic [DATA_W-1:0] pc_p1
);

  // Clear wins over load; a fetch landing during reset is never kept.
  always_ff @(posedge clk) begin
    if (clr) begin
      instr_p1 <= '0;
      pc_p1    <= '0;
    end else if (load) begin
      instr_p1 <= instr_p0;
      pc_p1    <= pc_p0;
    end
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch controller between the program counter register, instruction
// memory and decode. Issues one request at a time, buffers the returned
// word, hands it over with valid/ready, and steers the next PC on
// sequential fetch or on a branch/jump redirect. A misaligned PC parks
// the controller in an error state until reset.
module instr_fetch_ctrl
  import kgp_fetch_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int PC_STEP = PC_STEP_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pc_cur,
  output logic [DATA_W-1:0] pc_next,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [DATA_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] instr_pc,
  output logic              fetch_err
);

  localparam logic [DATA_W-1:0] STEP = DATA_W'(PC_STEP);

  fetch_state_t      state;
  logic [DATA_W-1:0] req_pc;
  logic              pc_ok;
  logic              cap_en;

  assign imem_addr = pc_cur;
  assign pc_ok     = pc_aligned(pc_cur[1:0]);

  // Only a clean response in S_WAIT is captured; a redirect in the same
  // cycle makes the word stale.
  assign cap_en = (state == S_WAIT) && imem_rvalid && !redirect;

  // Request generation and next-PC mux; redirect outranks sequential step.
  always_comb begin
    imem_req = 1'b0;
    pc_next  = pc_cur;
    if (!rst) begin
      if (state == S_REQ) begin
        imem_req = !redirect && pc_ok;
      end
      if (redirect && (state != S_ERR)) begin
        pc_next = redirect_pc;
      end else if (imem_req && imem_gnt) begin
        pc_next = pc_cur + STEP;
      end
    end
  end

  // Fetch FSM with registered valid/error flags and the request address.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
      req_pc      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          state <= S_REQ;
        end
        S_REQ: begin
          if (redirect) begin
            state <= S_REQ;
          end else if (!pc_ok) begin
            state     <= S_ERR;
            fetch_err <= 1'b1;
          end else if (imem_gnt) begin
            req_pc <= pc_cur;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cap_en) begin
            state       <= S_HOLD;
            instr_valid <= 1'b1;
          end else if (redirect && imem_rvalid) begin
            state <= S_REQ;
          end else if (redirect) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (imem_rvalid) begin
            state <= S_REQ;
          end
        end
        S_HOLD: begin
          if (redirect || instr_ready) begin
            state       <= S_REQ;
            instr_valid <= 1'b0;
          end
        end
        S_ERR: begin
          state     <= S_ERR;
          fetch_err <= 1'b1;
        end
        default: begin
          state       <= S_IDLE;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

  fetch_out_buf #(
    .DATA_W(DATA_W)
  ) u_out_buf (
    .clk      (clk),
    .clr      (rst),
    .load     (cap_en),
    .instr_p0 (imem_rdata),
    .pc_p0    (req_pc),
    .instr_p1 (instr),
    .pc_p1    (instr_pc)
  );

endmodule
